// File: rtl/aes_iter_cipher.sv
// rtl/aes_iter_cipher.sv - iterative AES-128 cipher, one round per clock, valid/ready handshakes
module aes_iter_cipher #(
    parameter int NR        = 10,
    parameter int FINAL_MIX = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [3:0] NR_L     = 4'(NR);
    localparam bit         LAST_MIX = (FINAL_MIX != 0);

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [1:0]   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] out_q, out_d;

    logic [127:0] next_key;
    logic [127:0] sb_state;
    logic [127:0] sr_state;
    logic [127:0] mc_state;
    logic [127:0] round_out;
    logic         use_mix;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round constants continue the GF(2^8) doubling sequence beyond round 10.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            4'd11:   return 8'h6c;
            4'd12:   return 8'hd8;
            4'd13:   return 8'hab;
            4'd14:   return 8'h4d;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // AES-128 key expansion step: four key S-box lookups on RotWord(w3).
    always_comb begin
        logic [31:0] rot_w;
        logic [31:0] temp_w;
        rot_w  = {key_q[23:0], key_q[31:24]};
        temp_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                  sbox(rot_w[15:8]),  sbox(rot_w[7:0])} ^ {rcon(rnd_q), 24'h0};
        next_key[127:96] = key_q[127:96] ^ temp_w;
        next_key[95:64]  = key_q[95:64]  ^ next_key[127:96];
        next_key[63:32]  = key_q[63:32]  ^ next_key[95:64];
        next_key[31:0]   = key_q[31:0]   ^ next_key[63:32];
    end

    // One cipher round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
    always_comb begin
        sb_state = '0;
        sr_state = '0;
        mc_state = '0;
        for (int i = 0; i < 16; i++) begin
            sb_state[127 - 8 * i -: 8] = sbox(state_q[127 - 8 * i -: 8]);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sr_state[127 - 8 * (r + 4 * c) -: 8] =
                    sb_state[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc_state[127 - 32 * c -: 32] = mix_col(sr_state[127 - 32 * c -: 32]);
        end
        use_mix   = (rnd_q != NR_L) || LAST_MIX;
        round_out = (use_mix ? mc_state : sr_state) ^ next_key;
    end

    // Control FSM and datapath next-state selection.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        out_d   = out_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = in_data ^ in_key;
                    key_d   = in_key;
                    rnd_d   = 4'd1;
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = round_out;
                key_d   = next_key;
                if (rnd_q == NR_L) begin
                    out_d = round_out;
                    fsm_d = S_DONE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
            out_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (fsm_q == S_IDLE) && !rst;
    assign out_valid = (fsm_q == S_DONE);
    assign busy      = (fsm_q == S_ROUND) || (fsm_q == S_DONE);
    assign out_data  = out_q;

endmodule
